// File: rtl/sevseg_scheduler.sv
// Round-robin bus master that time-shares one 7-segment display core between NUM_SRC producers,
// issuing single-cycle slot writes to the data (0x01) and config (0x00) registers.
module sevseg_scheduler #(
  parameter int NUM_SRC      = 4,
  parameter int DWELL_WIDTH  = 27,
  parameter int DWELL_CYCLES = 100000000,
  localparam int SrcW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [32*NUM_SRC-1:0]   src_value,
  input  logic                    hold_en,
  output logic                    cs,
  output logic                    write,
  output logic                    read,
  output logic [4:0]              address,
  output logic [31:0]             wr_data,
  output logic [SrcW-1:0]         cur_src,
  output logic                    active
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_DATA = 3'd1,
    S_WR_CFG  = 3'd2,
    S_DWELL   = 3'd3,
    S_BLANK   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [SrcW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [SrcW-1:0]        cur_src_q, cur_src_d;
  logic                   disp_on_q, disp_on_d;
  logic [31:0]            last_val_q, last_val_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic                   cs_q, cs_d;
  logic                   write_q, write_d;
  logic                   read_q, read_d;
  logic [4:0]             address_q, address_d;
  logic [31:0]            wr_data_q, wr_data_d;
  logic                   active_q, active_d;

  logic [31:0]            val_arr_s [NUM_SRC];
  logic                   sel_found_s;
  logic [SrcW-1:0]        sel_idx_s;
  logic [SrcW-1:0]        idx_s;
  int                     cand_s;
  logic                   expire_s;
  logic [DWELL_WIDTH-1:0] cnt_inc_s;
  logic [31:0]            cur_val_s;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_val
    assign val_arr_s[g] = src_value[32*g+31 : 32*g];
  end

  assign cur_val_s = val_arr_s[cur_src_q];
  assign expire_s  = (dwell_cnt_q == DWELL_WIDTH'(DWELL_CYCLES - 1));
  assign cnt_inc_s = expire_s ? '0 : dwell_cnt_q + DWELL_WIDTH'(1);

  // Round-robin pick: scan from rr_ptr+NUM_SRC down to rr_ptr+1 so the nearest valid index wins.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = rr_ptr_q;
    cand_s      = 0;
    idx_s       = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      cand_s      = int'(rr_ptr_q) + k;
      cand_s      = (cand_s >= NUM_SRC) ? cand_s - NUM_SRC : cand_s;
      idx_s       = SrcW'(cand_s);
      sel_found_s = sel_found_s | src_valid[idx_s];
      sel_idx_s   = src_valid[idx_s] ? idx_s : sel_idx_s;
    end
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= SrcW'(NUM_SRC - 1);
      cur_src_q   <= '0;
      disp_on_q   <= 1'b0;
      last_val_q  <= 32'h0;
      dwell_cnt_q <= '0;
      cs_q        <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      address_q   <= 5'h00;
      wr_data_q   <= 32'h0;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_src_q   <= cur_src_d;
      disp_on_q   <= disp_on_d;
      last_val_q  <= last_val_d;
      dwell_cnt_q <= dwell_cnt_d;
      cs_q        <= cs_d;
      write_q     <= write_d;
      read_q      <= read_d;
      address_q   <= address_d;
      wr_data_q   <= wr_data_d;
      active_q    <= active_d;
    end
  end

  // Next-state logic; the dwell counter runs in every non-idle state so refreshes do not stretch a slot.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cur_src_d   = cur_src_q;
    disp_on_d   = disp_on_q;
    last_val_d  = last_val_q;
    dwell_cnt_d = dwell_cnt_q;
    case (state_q)
      S_IDLE: begin
        dwell_cnt_d = '0;
        if (sel_found_s) begin
          state_d    = S_WR_DATA;
          cur_src_d  = sel_idx_s;
          rr_ptr_d   = sel_idx_s;
          last_val_d = val_arr_s[sel_idx_s];
        end else if (disp_on_q) begin
          state_d = S_BLANK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_DATA: begin
        dwell_cnt_d = cnt_inc_s;
        state_d     = disp_on_q ? S_DWELL : S_WR_CFG;
      end
      S_WR_CFG: begin
        dwell_cnt_d = cnt_inc_s;
        disp_on_d   = 1'b1;
        state_d     = S_DWELL;
      end
      S_DWELL: begin
        if (!src_valid[cur_src_q]) begin
          state_d     = S_IDLE;
          dwell_cnt_d = '0;
        end else if (cur_val_s != last_val_q) begin
          state_d     = S_WR_DATA;
          last_val_d  = cur_val_s;
          dwell_cnt_d = cnt_inc_s;
        end else if (expire_s && !hold_en) begin
          state_d     = S_IDLE;
          dwell_cnt_d = '0;
        end else begin
          state_d     = S_DWELL;
          dwell_cnt_d = cnt_inc_s;
        end
      end
      S_BLANK: begin
        disp_on_d   = 1'b0;
        dwell_cnt_d = '0;
        state_d     = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        dwell_cnt_d = '0;
      end
    endcase
  end

  // Bus outputs are decoded from the state being entered so each strobe lands in that state's cycle.
  always_comb begin
    cs_d      = 1'b0;
    write_d   = 1'b0;
    read_d    = 1'b0;
    address_d = address_q;
    wr_data_d = wr_data_q;
    active_d  = active_q;
    case (state_d)
      S_WR_DATA: begin
        cs_d      = 1'b1;
        write_d   = 1'b1;
        address_d = 5'h01;
        wr_data_d = last_val_d;
      end
      S_WR_CFG: begin
        cs_d      = 1'b1;
        write_d   = 1'b1;
        address_d = 5'h00;
        wr_data_d = 32'h1;
        active_d  = 1'b1;
      end
      S_BLANK: begin
        cs_d      = 1'b1;
        write_d   = 1'b1;
        address_d = 5'h00;
        wr_data_d = 32'h0;
        active_d  = 1'b0;
      end
      default: begin
        cs_d    = 1'b0;
        write_d = 1'b0;
      end
    endcase
  end

  assign cs      = cs_q;
  assign write   = write_q;
  assign read    = read_q;
  assign address = address_q;
  assign wr_data = wr_data_q;
  assign cur_src = cur_src_q;
  assign active  = active_q;

endmodule

// File: doc/sevseg_scheduler.md
Name: sevseg_scheduler

Overview:
- Bus-master scheduler for the 7-segment display MMIO core.
- Time-shares the single display between NUM_SRC requesters: round-robin, fixed dwell time per requester.
- Drives the display's slot-interface writes: config register at address 0x00 (bit0 = display enable) and data register at address 0x01 (8 hex nibbles).
- Sits between on-chip producers (counters, status, debug values) and the display core instance.

Parameters:
- NUM_SRC, 4, number of requesters (2..8).
- DWELL_WIDTH, 27, dwell counter width.
- DWELL_CYCLES, 100000000, clock cycles a selected source stays on the display (must be ≥ 2 and < 2**DWELL_WIDTH).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- src_valid  in  NUM_SRC  bit i high = source i requests display time.
- src_value  in  32*NUM_SRC  source i value at bits [32*i+31 : 32*i].
- hold_en  in  1  when high, dwell expiry does not rotate; current source stays selected.
- cs  out  1  slot chip select, asserted only together with write.
- write  out  1  slot write strobe.
- read  out  1  constant 0.
- address  out  5  slot register address: 0x00 config, 0x01 data.
- wr_data  out  32  slot write data.
- cur_src  out  clog2(NUM_SRC)  index of the source currently displayed.
- active  out  1  high while the display is enabled by this block.

Behaviour:
- All outputs are registered.
- Reset values:
  - cs, write, read, active = 0; address = 0; wr_data = 0; cur_src = 0.
  - Internal state: state = IDLE, rr_ptr = NUM_SRC-1, disp_on = 0, last_val = 0, dwell_cnt = 0.
- Reset mid-operation aborts immediately. No blank write is issued; the display core is expected to share the same reset.
- Bus strobes:
  - cs = write = 1 for exactly one cycle per transaction. The core has no ready/backpressure, so every write completes in that cycle.
  - address and wr_data are valid in the same cycle; both hold their last value otherwise.
- States: IDLE, WR_DATA, WR_CFG, DWELL, BLANK.
- IDLE:
  - If any src_valid bit is high, select sel = first valid index strictly after rr_ptr, wrapping modulo NUM_SRC. If only rr_ptr's own source is valid, that source is selected again.
  - On selection: latch cur_src = sel, rr_ptr = sel, last_val = src_value[sel] → WR_DATA.
  - Else if disp_on = 1 → BLANK.
  - Else remain in IDLE.
- WR_DATA:
  - Drive write to address 0x01 with wr_data = last_val.
  - Next state: if disp_on = 0 → WR_CFG; else → DWELL.
- WR_CFG:
  - Drive write to address 0x00 with wr_data = 32'h1.
  - Set disp_on = 1 and active = 1 → DWELL.
- DWELL:
  - dwell_cnt increments every cycle. On reaching DWELL_CYCLES-1 it wraps to 0 and expires.
  - Priority order, each cycle:
    1. src_valid[cur_src] = 0 → IDLE immediately; dwell_cnt cleared.
    2. src_value[cur_src] ≠ last_val → last_val updated, → WR_DATA (refresh). dwell_cnt is NOT cleared and keeps counting through the refresh.
    3. Expiry with hold_en = 1 → stay in DWELL; counter restarts.
    4. Expiry with hold_en = 0 → IDLE; dwell_cnt cleared.
- BLANK:
  - Drive write to address 0x00 with wr_data = 0.
  - Clear disp_on and active → IDLE.
- Timing from entering IDLE with display off and a request present:
  - Cycle +1: data write.
  - Cycle +2: config write.
  - cur_src is updated at the data write.
- Timing with display already on: only the data write; the config write is skipped.
- Source switch while the display is on: no blank is issued; the display changes directly.
- Rotation: a source dropping src_valid is simply skipped on later arbitrations.
- Simultaneous events:
  - Valid drop and value change in the same cycle: the drop wins.
  - A new request arriving mid-dwell does not pre-empt the current source.

Test Plan:
- Single source, cold start. After reset, src_valid = 4'b0001, value0 = 32'h1234ABCD → write (0x01, 32'h1234ABCD), then next cycle write (0x00, 32'h1), active = 1, cur_src = 0, no further writes.
- Round-robin. DWELL_CYCLES = 8, all four sources valid, values 32'h0/1/2/3 → data writes in order 0, 1, 2, 3, 0, spaced 9 cycles apart (8 dwell + 1 write). Exactly one config write total.
- Value refresh. Source 2 displayed; change value2 to 32'hDEAD0002 mid-dwell → one data write with 32'hDEAD0002 on the following cycle; rotation time is unchanged.
- Drop and blank. Only source 1 valid and displayed; deassert src_valid → next cycle in IDLE, following cycle write (0x00, 32'h0), active = 0.
- hold_en. DWELL_CYCLES = 8, sources 0 and 3 valid, hold_en = 1 while source 0 is displayed → no rotation for 50 cycles. Release hold_en → source 3 data write within 9 cycles.
- Reset mid-dwell → all outputs return to reset values next cycle. First post-reset arbitration selects index 0 (given src_valid[0] = 1).
